// File: rtl/mpc_select_pkg.sv
// rtl/mpc_select_pkg.sv - register offsets, status bit positions and sequencer states
package mpc_select_pkg;

  localparam logic [7:0] SEL_BASE_OFF = 8'h00;
  localparam logic [7:0] STATUS_OFF   = 8'h20;
  localparam logic [7:0] LOCK_OFF     = 8'h24;

  localparam int STATUS_ERR_BIT  = 8;
  localparam int STATUS_LOCK_BIT = 9;
  localparam int LOCK_SET_BIT    = 0;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ISO_PRE,
    SEQ_SWITCH,
    SEQ_ISO_POST
  } seq_state_e;

endpackage

// File: rtl/mpc_switch_seq.sv
// rtl/mpc_switch_seq.sv - per-line sequencer wrapping every select change in isolation windows
module mpc_switch_seq
  import mpc_select_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int ISO_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [SEL_W-1:0] pending_i,
  input  logic [SEL_W-1:0] pending_nxt_i,
  output logic [SEL_W-1:0] applied_o,
  output logic             iso_o,
  output logic             busy_o
);

  localparam int CNT_W = (ISO_CYCLES > 1) ? $clog2(ISO_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ISO_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] applied_q, applied_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= SEQ_IDLE;
      cnt_q     <= '0;
      applied_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      applied_q <= applied_d;
    end
  end

  // Capture uses the incoming pending value so a write landing on the capture edge wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    applied_d = applied_q;
    case (state_q)
      SEQ_IDLE: begin
        cnt_d = '0;
        if (pending_i != applied_q) state_d = SEQ_ISO_PRE;
      end
      SEQ_ISO_PRE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = SEQ_SWITCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SEQ_SWITCH: begin
        applied_d = pending_nxt_i;
        state_d   = SEQ_ISO_POST;
      end
      SEQ_ISO_POST: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = SEQ_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  assign applied_o = applied_q;
  assign iso_o     = (state_q != SEQ_IDLE);
  assign busy_o    = (state_q != SEQ_IDLE);

endmodule

// File: rtl/mpc_select_ctrl.sv
// rtl/mpc_select_ctrl.sv - Wishbone register block owning per-line select sequencers
module mpc_select_ctrl
  import mpc_select_pkg::*;
#(
  parameter int          N_VLINES   = 2,
  parameter int          N_MACROS   = 3,
  parameter int          SEL_W      = 3,
  parameter int          ISO_CYCLES = 4,
  parameter logic [31:0] BASE_ADR   = 32'h3000_0000
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_dat_i,
  input  logic [31:0]               wbs_adr_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  output logic [N_VLINES*SEL_W-1:0] sel_o,
  output logic [N_VLINES-1:0]       iso_o,
  output logic [N_VLINES-1:0]       busy_o
);

  logic                      ack_q;
  logic [31:0]               dat_q, dat_d;
  logic                      lock_q, lock_d, err_q, err_d;
  logic [N_VLINES*SEL_W-1:0] pend_q, pend_d, applied;
  logic                      access, hit;
  logic [7:0]                off;
  logic                      unused_bits;

  assign access      = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign hit         = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign off         = wbs_adr_i[7:0];
  assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      lock_q <= 1'b0;
      err_q  <= 1'b0;
      pend_q <= '0;
    end else begin
      ack_q  <= access;
      dat_q  <= dat_d;
      lock_q <= lock_d;
      err_q  <= err_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    pend_d = pend_q;
    lock_d = lock_q;
    err_d  = err_q;
    dat_d  = '0;
    if (access && hit) begin
      for (int i = 0; i < N_VLINES; i++) begin
        if (off == SEL_BASE_OFF + 8'(4 * i)) begin
          if (wbs_we_i && wbs_sel_i[0]) begin
            if (lock_q || ({1'b0, wbs_dat_i[SEL_W-1:0]} >= (SEL_W+1)'(N_MACROS)))
              err_d = 1'b1;
            else
              pend_d[i*SEL_W +: SEL_W] = wbs_dat_i[SEL_W-1:0];
          end
          dat_d[8 +: SEL_W] = pend_q[i*SEL_W +: SEL_W];
          dat_d[0 +: SEL_W] = applied[i*SEL_W +: SEL_W];
        end
      end
      if (off == STATUS_OFF) begin
        if (wbs_we_i && wbs_dat_i[STATUS_ERR_BIT]) err_d = 1'b0;
        dat_d[N_VLINES-1:0]     = busy_o;
        dat_d[STATUS_ERR_BIT]   = err_q;
        dat_d[STATUS_LOCK_BIT]  = lock_q;
      end
      if (off == LOCK_OFF) begin
        if (wbs_we_i && wbs_dat_i[LOCK_SET_BIT]) lock_d = 1'b1;
        dat_d[LOCK_SET_BIT] = lock_q;
      end
    end
  end

  for (genvar g = 0; g < N_VLINES; g++) begin : g_line
    mpc_switch_seq #(
      .SEL_W      (SEL_W),
      .ISO_CYCLES (ISO_CYCLES)
    ) u_seq (
      .clk_i         (wb_clk_i),
      .rst_i         (wb_rst_i),
      .pending_i     (pend_q[g*SEL_W +: SEL_W]),
      .pending_nxt_i (pend_d[g*SEL_W +: SEL_W]),
      .applied_o     (applied[g*SEL_W +: SEL_W]),
      .iso_o         (iso_o[g]),
      .busy_o        (busy_o[g])
    );
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign sel_o     = applied;

endmodule

// File: tb/tb_mpc_select_ctrl.sv
// tb/tb_mpc_select_ctrl.sv - scoreboard bench for mpc_select_ctrl
module tb_mpc_select_ctrl;

  localparam logic [31:0] A_SEL0   = 32'h3000_0000;
  localparam logic [31:0] A_SEL1   = 32'h3000_0004;
  localparam logic [31:0] A_STATUS = 32'h3000_0020;
  localparam logic [31:0] A_LOCK   = 32'h3000_0024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  bsel = 4'h0;
  logic [31:0] wdat = '0, adr = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [5:0]  sel_o;
  logic [1:0]  iso_o, busy_o;

  typedef struct { int cyc; logic [5:0] sel; logic [1:0] iso; } ev_t;
  typedef struct { logic rd; logic [31:0] exp; } tr_t;
  ev_t ev_q[$];
  tr_t tr_q[$];

  int checks = 0, errors = 0, cyc_cnt = 0, a;
  logic       mon_en = 1'b0;
  logic [5:0] prev_sel;
  logic [1:0] prev_iso;

  mpc_select_ctrl dut (
    .wb_clk_i (clk), .wb_rst_i (rst),
    .wbs_stb_i (stb), .wbs_cyc_i (cyc), .wbs_we_i (we), .wbs_sel_i (bsel),
    .wbs_dat_i (wdat), .wbs_adr_i (adr), .wbs_ack_o (ack), .wbs_dat_o (rdat),
    .sel_o (sel_o), .iso_o (iso_o), .busy_o (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc_cnt);
    $fatal(1);
  end

  // WB monitor: every ack pops one transaction, reads compare data
  always @(negedge clk) begin
    if (ack) begin
      if (tr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack at cycle %0d", cyc_cnt);
      end else begin
        tr_t t;
        t = tr_q.pop_front();
        if (t.rd) begin
          checks++;
          if (rdat !== t.exp) begin
            errors++;
            $display("FAIL read_data got %h expected %h at cycle %0d", rdat, t.exp, cyc_cnt);
          end
        end
      end
    end
  end

  // Output monitor: every change of sel/iso must match the next expected event
  always @(negedge clk) begin
    if (mon_en) begin
      if (sel_o !== prev_sel || iso_o !== prev_iso) begin
        checks++;
        if (ev_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change sel=%h iso=%b at cycle %0d", sel_o, iso_o, cyc_cnt);
        end else begin
          ev_t e;
          e = ev_q.pop_front();
          if (cyc_cnt != e.cyc || sel_o !== e.sel || iso_o !== e.iso || busy_o !== e.iso) begin
            errors++;
            $display("FAIL out_event got cyc=%0d sel=%h iso=%b busy=%b expected cyc=%0d sel=%h iso=%b",
                     cyc_cnt, sel_o, iso_o, busy_o, e.cyc, e.sel, e.iso);
          end
        end
      end
      prev_sel = sel_o;
      prev_iso = iso_o;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic ev(input int c, input logic [5:0] s, input logic [1:0] i);
    ev_q.push_back('{c, s, i});
  endtask

  // Starts at a negedge; returns at the negedge of the ack cycle with its cycle number
  task automatic xfer(input logic w, input logic [31:0] ad, input logic [31:0] d,
                      input logic [31:0] exp, output int ack_cyc);
    int n;
    if (ack) @(negedge clk);
    tr_q.push_back('{!w, exp});
    stb = 1'b1; cyc = 1'b1; we = w; adr = ad; wdat = d; bsel = 4'hf;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    checks++;
    if (!ack || n != 1) begin
      errors++;
      $display("FAIL ack_latency got %0d cycles expected 1", n);
    end
    ack_cyc = cyc_cnt;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] ad, input logic [31:0] d, output int ack_cyc);
    xfer(1'b1, ad, d, 32'h0, ack_cyc);
  endtask

  task automatic rd(input logic [31:0] ad, input logic [31:0] exp);
    int c;
    xfer(1'b0, ad, 32'h0, exp, c);
  endtask

  task automatic pulse_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    prev_sel = sel_o;
    prev_iso = iso_o;
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sel", 32'(sel_o), 32'h0);
    chk("rst_iso", 32'(iso_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_dat", rdat, 32'h0);
    rst = 1'b0;
    prev_sel = sel_o;
    prev_iso = iso_o;
    mon_en = 1'b1;
    @(negedge clk);
    rd(A_SEL0, 32'h0);
    rd(A_STATUS, 32'h0);

    wr(A_SEL1, 32'd2, a);
    ev(a + 1, 6'h00, 2'b10);
    ev(a + 6, 6'h10, 2'b10);
    ev(a + 10, 6'h10, 2'b00);
    rd(A_SEL1, 32'h0000_0200);
    rd(A_STATUS, 32'h0000_0002);
    repeat (12) @(negedge clk);
    rd(A_SEL1, 32'h0000_0202);

    wr(A_SEL0, 32'd3, a);
    rd(A_STATUS, 32'h0000_0100);
    wr(A_STATUS, 32'h0000_0100, a);
    rd(A_STATUS, 32'h0);
    wr(A_SEL1, 32'd2, a);
    repeat (3) @(negedge clk);

    // second write lands in ISO_PRE: one switch straight to 2
    wr(A_SEL0, 32'd1, a);
    ev(a + 1, 6'h10, 2'b01);
    ev(a + 6, 6'h12, 2'b01);
    ev(a + 10, 6'h12, 2'b00);
    wr(A_SEL0, 32'd2, a);
    repeat (12) @(negedge clk);
    rd(A_SEL0, 32'h0000_0202);

    // second write lands in ISO_POST: switch to 1, then a full sequence to 2
    wr(A_SEL0, 32'd1, a);
    ev(a + 1, 6'h12, 2'b01);
    ev(a + 6, 6'h11, 2'b01);
    ev(a + 10, 6'h11, 2'b00);
    ev(a + 11, 6'h11, 2'b01);
    ev(a + 16, 6'h12, 2'b01);
    ev(a + 20, 6'h12, 2'b00);
    repeat (6) @(negedge clk);
    wr(A_SEL0, 32'd2, a);
    repeat (16) @(negedge clk);

    // second write acked in the SWITCH cycle: new value captured, sel unchanged
    wr(A_SEL0, 32'd1, a);
    ev(a + 1, 6'h12, 2'b01);
    ev(a + 10, 6'h12, 2'b00);
    repeat (4) @(negedge clk);
    wr(A_SEL0, 32'd2, a);
    repeat (12) @(negedge clk);

    rd(32'h3000_0040, 32'h0);
    wr(32'h4000_0000, 32'd1, a);
    rd(32'h4000_0020, 32'h0);
    repeat (3) @(negedge clk);

    wr(A_LOCK, 32'h1, a);
    wr(A_SEL0, 32'd1, a);
    rd(A_STATUS, 32'h0000_0300);
    rd(A_SEL0, 32'h0000_0202);
    repeat (3) @(negedge clk);

    pulse_reset();
    rd(A_STATUS, 32'h0);
    rd(A_SEL0, 32'h0);

    // reset in the middle of ISO_POST
    wr(A_SEL0, 32'd2, a);
    ev(a + 1, 6'h00, 2'b01);
    ev(a + 6, 6'h02, 2'b01);
    repeat (7) @(negedge clk);
    mon_en = 1'b0;
    chk("events_before_reset", 32'(ev_q.size()), 32'h0);
    chk("mid_post_sel", 32'(sel_o), 32'h2);
    rst = 1'b1;
    #1;
    chk("async_rst_sel", 32'(sel_o), 32'h0);
    chk("async_rst_iso", 32'(iso_o), 32'h0);
    chk("async_rst_busy", 32'(busy_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    prev_sel = sel_o;
    prev_iso = iso_o;
    mon_en = 1'b1;
    @(negedge clk);
    rd(A_SEL0, 32'h0);
    repeat (12) @(negedge clk);

    chk("events_left", 32'(ev_q.size()), 32'h0);
    chk("transactions_left", 32'(tr_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpc_select_ctrl.md
Name: mpc_select_ctrl

Overview:
Wishbone-slave configuration block that produces the per-vertical-line macro `select` codes consumed by the vertical-line mux stages of the multi-project fabric. It owns one switch sequencer per vertical line. Each sequencer asserts an isolation strobe before and after a select change, so the pads never see a glitching output-enable. It sits directly upstream of every vertical line and shares their buffered Wishbone bus.

Parameters:
N_VLINES, 2, number of vertical lines driven (1..8)
N_MACROS, 3, valid select codes are 0..N_MACROS-1
SEL_W, 3, width of one select code
ISO_CYCLES, 4, isolation hold cycles before and after a switch (>=1)
BASE_ADR, 32'h3000_0000, Wishbone base; decode on adr[31:8]

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  asynchronous, active-high reset
wbs_stb_i  in  1  WB strobe
wbs_cyc_i  in  1  WB cycle
wbs_we_i  in  1  WB write enable
wbs_sel_i  in  4  WB byte selects
wbs_dat_i  in  32  WB write data
wbs_adr_i  in  32  WB address
wbs_ack_o  out  1  WB acknowledge
wbs_dat_o  out  32  WB read data
sel_o  out  N_VLINES*SEL_W  applied select per line; line i occupies [i*SEL_W +: SEL_W]
iso_o  out  N_VLINES  per-line isolation; downstream forces that line's selected OE low while high
busy_o  out  N_VLINES  per-line sequencer not IDLE

Behaviour:
- Reset (async, active-high):
  - sel_o=0, iso_o=0, busy_o=0, wbs_ack_o=0, wbs_dat_o=0.
  - pending=0, lock=0, err=0, all sequencers IDLE.
- Register map (byte offsets from BASE_ADR):
  - 0x00+4*i, SELi: write [2:0]=requested select (effective only if wbs_sel_i[0]). Read: {21'b0, pending[10:8], 5'b0, applied[2:0]}.
  - 0x20, STATUS: read [N_VLINES-1:0]=busy, [8]=err, [9]=lock. Writing 1 to bit 8 clears err; bits 0..7 and 9 are read-only.
  - 0x24, LOCK: writing 1 to bit 0 sets lock. Lock clears only on reset.
- WB timing:
  - ack asserts exactly 1 cycle after stb&cyc is seen with ack low, and is high for one cycle only.
  - Back-to-back accesses therefore take 2 cycles each.
  - Read data is valid in the ack cycle.
  - Unmapped offsets and adr[31:8]!=BASE_ADR[31:8] still ack: reads return 0, writes have no effect.
- SELi write rules:
  - Code >= N_MACROS: ignored, err set.
  - lock=1: ignored, err set.
  - Otherwise pending[i] is updated. Latest write wins, including while the line is busy.
- Sequencer per line, states IDLE, ISO_PRE, SWITCH, ISO_POST:
  - IDLE: if pending!=applied, go to ISO_PRE and assert iso. Otherwise stay.
  - ISO_PRE: iso=1; counts ISO_CYCLES cycles, then SWITCH.
  - SWITCH: 1 cycle; applied<=pending captured at that edge; iso=1.
  - ISO_POST: iso=1 for ISO_CYCLES cycles, then IDLE with iso=0.
  - busy_o = state!=IDLE.
- Latency: from the ack cycle of an effective write, sel_o changes ISO_CYCLES+2 cycles later. iso_o then drops ISO_CYCLES cycles after that.
- Simultaneous events:
  - A pending update in SWITCH's capture cycle: the new value is captured.
  - A pending update after SWITCH: a full second sequence runs from IDLE, with no shortcut.
  - Writing pending equal to applied in IDLE: no sequence, iso stays 0.
- Reset mid-sequence: immediate return to reset values, including iso=0 and sel=0.
- Lines are independent and may sequence concurrently.

Decomposition:
- Package mpc_select_pkg holds:
  - register offsets (SEL_BASE_OFF, STATUS_OFF, LOCK_OFF);
  - STATUS bit indices;
  - the sequencer state enum.
- Sub-module mpc_switch_seq (one per line, generate loop) takes pending/applied/iso/busy and ISO_CYCLES.
- The top level holds WB decode, pending registers, lock and err.

Test Plan:
- Reset, then read SEL0 and STATUS -> 0x0 and 0x0; sel_o=0, iso_o=0.
- Write SEL1=2 (ISO_CYCLES=4) -> ack 1 cycle later; iso_o[1] rises next cycle; sel_o line1=2 six cycles after ack; iso_o[1] low four cycles later; line0 untouched.
- Write SEL0=3 -> err=1, no sequence. Write STATUS=0x100 -> err=0.
- Write SEL0=1, then SEL0=2 during ISO_PRE -> exactly one switch, to 2. Repeat with the second write in ISO_POST -> switch to 1 then a second full sequence to 2.
- Write LOCK=1, then SEL0=1 -> ignored, err=1, STATUS[9]=1. Reset -> lock=0.
- Assert wb_rst_i mid-ISO_POST with sel line0=2 -> same-cycle sel_o=0, iso_o=0, busy_o=0.
